// File: rtl/pifo_pkg.sv
// pifo_pkg: shared widths and FSM encoding for the PIFO dequeue side.
package pifo_pkg;
  localparam int RANK_W = 8;
  localparam int META_W = 8;
  localparam int POP_CNT_W = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, POP = 2'd1, SETTLE = 2'd2} state_t;
endpackage

// File: rtl/pifo_reader_if.sv
// pifo_reader_if: downstream valid/ready stream carrying popped rank/meta pairs.
interface pifo_reader_if
  import pifo_pkg::*;
#(
  parameter int RANK_WIDTH = RANK_W,
  parameter int META_WIDTH = META_W
);
  logic                  m_valid;
  logic                  m_ready;
  logic [RANK_WIDTH-1:0] m_rank;
  logic [META_WIDTH-1:0] m_meta;
  modport master(output m_valid, m_rank, m_meta, input m_ready);
  modport slave(input m_valid, m_rank, m_meta, output m_ready);
endinterface

// File: rtl/pifo_reader_buf.sv
// pifo_reader_buf: small circular sync FIFO; head reads as zero while empty.
module pifo_reader_buf
  import pifo_pkg::*;
#(
  parameter int WIDTH = RANK_W + META_W,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign rd_data = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
endmodule

// File: rtl/pifo_reader.sv
// pifo_reader: pops the PIFO head with pacing and streams captured pairs downstream.
module pifo_reader
  import pifo_pkg::*;
#(
  parameter int RANK_WIDTH = RANK_W,
  parameter int META_WIDTH = META_W,
  parameter int BUF_DEPTH  = 2,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [GAP_WIDTH-1:0]  min_gap,
  input  logic                  pifo_valid_out,
  input  logic [RANK_WIDTH-1:0] pifo_rank_out,
  input  logic [META_WIDTH-1:0] pifo_meta_out,
  output logic                  pifo_remove,
  output logic [POP_CNT_W-1:0]  pop_count,
  output logic                  pop_err,
  pifo_reader_if.master         m
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  state_t state, state_nxt;
  logic [GAP_WIDTH-1:0] gap_cnt;
  logic [CW-1:0] count;
  logic launch, capture, buf_full, buf_empty, xfer;
  assign launch = enable && pifo_valid_out && count < DEPTH_C && gap_cnt == '0;
  assign capture = state == POP && pifo_valid_out && !buf_full;
  assign xfer = m.m_valid && m.m_ready;
  assign m.m_valid = !buf_empty;
  // POP always lasts one cycle so the head is never sampled right after a pop.
  always_comb begin
    state_nxt = state == POP ? SETTLE : (launch ? POP : IDLE);
    pifo_remove = state == POP;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      gap_cnt <= '0;
      pop_count <= '0;
      pop_err <= 1'b0;
    end else begin
      state <= state_nxt;
      gap_cnt <= state == POP ? min_gap : (gap_cnt != '0 ? gap_cnt - 1'b1 : gap_cnt);
      if (state == POP) begin
        pop_count <= pop_count + 1'b1;
        pop_err <= pop_err | !pifo_valid_out;
      end
    end
  pifo_reader_buf #(.WIDTH(RANK_WIDTH + META_WIDTH), .DEPTH(BUF_DEPTH)) u_buf (
    .clk(clk),
    .rst(rst),
    .wr_en(capture),
    .wr_data({pifo_rank_out, pifo_meta_out}),
    .rd_en(xfer),
    .rd_data({m.m_rank, m.m_meta}),
    .count(count),
    .full(buf_full),
    .empty(buf_empty)
  );
endmodule

// File: doc/pifo_reader.md
# pifo_reader

Dequeue-side controller for the register-based PIFO (`pifo_reg`).
- Watches the PIFO head, issues single-cycle `remove` pulses and captures each popped rank/meta pair.
- Presents the captured pairs downstream as a valid/ready stream through a small output buffer.
- Supports pacing (minimum spacing between pops) and a global enable.
- Sits between the PIFO and the egress/output-queue logic; the enqueue side (`insert`) is out of scope.

## Interface
- `RANK_WIDTH`, 8, rank width; must match the PIFO.
- `META_WIDTH`, 8, metadata width; must match the PIFO.
- `BUF_DEPTH`, 2, output buffer entries; must be a power of two, ≥2.
- `GAP_WIDTH`, 8, width of `min_gap`.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  pops may start only while high.
- `min_gap`  in  GAP_WIDTH  extra idle cycles between pops; sampled at each POP.
- `pifo_valid_out`  in  1  PIFO head is valid.
- `pifo_rank_out`  in  RANK_WIDTH  PIFO head rank.
- `pifo_meta_out`  in  META_WIDTH  PIFO head metadata.
- `pifo_remove`  out  1  registered pop strobe to the PIFO.
- `m_valid`  out  1  buffer head valid.
- `m_ready`  in  1  downstream accepts.
- `m_rank`  out  RANK_WIDTH  buffer head rank.
- `m_meta`  out  META_WIDTH  buffer head metadata.
- `pop_count`  out  16  pops issued; wraps modulo 2^16.
- `pop_err`  out  1  sticky; set if `pifo_valid_out` was low during POP.

## Operation
- **PIFO contract:**
  - `remove` is sampled at the rising edge.
  - Head outputs are stable in the cycle `remove` is high.
  - The new head is valid one full cycle later.
  - Consequently, the head is never sampled in the cycle after a pop.
- **Launch condition L:** `enable && pifo_valid_out && count < BUF_DEPTH && gap_cnt == 0`.
  - `count` already includes any entry captured at a prior POP.
- **FSM states:** IDLE, POP, SETTLE.
  - IDLE: if L, go to POP; else stay in IDLE.
  - POP: `pifo_remove`=1. At the closing edge:
    - capture rank/meta into the buffer if `pifo_valid_out`; otherwise set `pop_err` and capture nothing;
    - `pop_count`++;
    - load `gap_cnt` ← `min_gap`;
    - go to SETTLE.
  - SETTLE: `pifo_remove`=0. If L, go to POP; else go to IDLE.
- **gap_cnt:** decrements by 1 each cycle while nonzero, except on the POP load edge. It never underflows.
- **Output buffer:**
  - Circular FIFO with read/write pointers of log2(BUF_DEPTH) bits; pointers wrap naturally.
  - `m_valid` = (`count` != 0).
  - `m_rank`/`m_meta` show the read-pointer entry.
  - A transfer occurs when `m_valid && m_ready`.
  - Capture and transfer in the same cycle leaves `count` unchanged.
  - Writes never occur when full, because L guarantees space.
- **Enable deasserted during POP:** the POP completes. No new launch until `enable` returns.
- **Reset (any time, including mid-POP):**
  - state=IDLE, `pifo_remove`=0, `count`=0, pointers=0, `gap_cnt`=0, `pop_count`=0, `pop_err`=0, `m_valid`=0.
  - `m_rank`/`m_meta` = 0.

## Timing
- Pop spacing is 2 + `min_gap` cycles, measured from one `pifo_remove` rising edge to the next.
  - Maximum rate is one pop every 2 cycles.
- Latency: if L holds in cycle t (IDLE), `pifo_remove` is high in t+1 and `m_valid` is high in t+2.
- Buffer full with `m_ready`=0: pops stall.
  - One transfer frees a slot, and L may be met in the following cycle.
- `m_valid`/`m_rank`/`m_meta` must stay stable while `m_ready`=0.

## Structure
- **Shared package `pifo_pkg`:**
  - default RANK/META widths;
  - state enum (IDLE/POP/SETTLE, 2-bit encoding);
  - `pop_count` width constant.
- **Sub-module `pifo_reader_buf`:** parameterised sync FIFO with `count`, `full`, `empty`.
- **Top level:** FSM, gap counter, statistics.

## Test plan
- **Ordering:** PIFO (MIN, size 8) preloaded with ranks 8,87,54,76,47 (meta 0x20..0x60), `enable`=1, `m_ready`=1.
  - Required: `m_rank` sequence 8,47,54,76,87 with meta 0x20,0x60,0x40,0x50,0x30.
  - Required: `pifo_remove` pulses exactly 2 cycles apart; `pop_count`=5.
- **Backpressure:** same preload, `m_ready`=0.
  - Required: exactly 2 pops, then `pifo_remove` stays 0 and `m_rank` holds 8.
  - Raise `m_ready` for one cycle → `m_rank`=47, and one further pop occurs.
- **Pacing:** `min_gap`=3 with 3 entries queued.
  - Required: pops 5 cycles apart.
  - Changing `min_gap` to 0 after the first pop takes effect from the second POP's load.
- **Enable:** `enable`=0 with 4 entries queued → no `pifo_remove` for 20 cycles.
  - Drop `enable` in a POP cycle → that pop completes; no subsequent pop.
- **Reset mid-operation:** assert `rst` asynchronously during POP with 1 buffered entry.
  - Required: `pifo_remove`, `m_valid`, `pop_count` and `pop_err` drop to 0 immediately.
  - Required: after release, draining resumes correctly.
- **Error:** force `pifo_valid_out` low during a POP → `pop_err`=1 sticky; `count` unchanged; `pop_count` still increments.
